// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver with FWFT RX FIFO and sticky error flags; UART_RX_PARITY_EN adds parity check
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY_ODD = 0,
   localparam int AW = $clog2(FIFO_DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 empty,
   output logic                 full,
   output logic [AW:0]          count,
   output logic                 overflow,
   output logic                 frame_err,
   output logic                 parity_err,
   input  logic                 clr_err
);
   localparam int DIV = CLK_FREQ / (BAUD * 16);
   localparam int TW  = $clog2(DIV + 1);
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HIGH
   } state_t;
   state_t state, state_n;
   logic s1, rx_s, tick, bit_done, start, push_req, push, set_fe, bad_par, do_wr, do_rd;
   logic [TW-1:0] tcnt;
   logic [3:0] scnt, bcnt;
   logic [DATA_BITS-1:0] sh;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
`ifdef UART_RX_PARITY_EN
   logic set_pe;
`endif
   assign tick     = tcnt == TW'(DIV - 1);
   assign bit_done = tick && scnt == (state == START ? 4'd7 : 4'd15);
   assign start    = state == IDLE && !rx_s;
   always_comb begin
      state_n  = state;
      push_req = 1'b0;
      set_fe   = 1'b0;
`ifdef UART_RX_PARITY_EN
      set_pe   = 1'b0;
`endif
      case (state)
         IDLE:      state_n = rx_s ? IDLE : START;
         START:     if (bit_done) state_n = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:      if (bit_done && bcnt == 4'(DATA_BITS - 1)) state_n = PARITY;
         PARITY: if (bit_done) begin
            state_n = STOP;
            set_pe  = (^sh ^ rx_s) != 1'(PARITY_ODD);
         end
`else
         DATA:      if (bit_done && bcnt == 4'(DATA_BITS - 1)) state_n = STOP;
`endif
         STOP: if (bit_done) begin
            state_n  = rx_s ? IDLE : WAIT_HIGH;
            push_req = rx_s && !bad_par;
            set_fe   = !rx_s;
         end
         WAIT_HIGH: if (rx_s) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   // Counters restart on start detect so mid-bit sampling is aligned to the falling edge
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1   <= 1'b1;
         rx_s <= 1'b1;
         tcnt <= '0;
         scnt <= '0;
         bcnt <= '0;
         sh   <= '0;
         push <= 1'b0;
      end else begin
         s1   <= rx;
         rx_s <= s1;
         push <= push_req;
         tcnt <= (start || tick) ? '0 : tcnt + TW'(1);
         if (start) scnt <= '0;
         else if (tick && state != IDLE && state != WAIT_HIGH) scnt <= bit_done ? 4'd0 : scnt + 4'd1;
         if (state == START) bcnt <= '0;
         else if (state == DATA && bit_done) begin
            sh   <= {rx_s, sh[DATA_BITS-1:1]};
            bcnt <= bcnt + 4'd1;
         end
      end
`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bad_par    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         bad_par    <= start ? 1'b0 : (bad_par || set_pe);
         parity_err <= set_pe || (parity_err && !clr_err);
      end
`else
   assign bad_par    = 1'b0;
   assign parity_err = 1'b0;
`endif
   assign empty   = count == '0;
   assign full    = count == (AW+1)'(FIFO_DEPTH);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = push && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rp];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (do_wr) wp <= wp + AW'(1);
         if (do_rd) rp <= rp + AW'(1);
         count     <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
         overflow  <= (push && full && !rd_en) || (overflow && !clr_err);
         frame_err <= set_fe || (frame_err && !clr_err);
      end
   always_ff @(posedge clk)
      if (do_wr) mem[wp] <= sh;
endmodule
